// File: rtl/dcm_ramp_controller.sv
// ---------------------------------------------------------------------------
// dcm_ramp_controller
//   Multi-channel DCM_CLKGEN frequency controller. Accepts validated clock
//   commands, then walks each DCM's multiplier toward its target in bounded
//   steps. It drives the serial programming port of NUM_DCM DCMs from one
//   clock and waits out a settle interval after every program. A program
//   whose PROGDONE never arrives marks that channel with a sticky error and
//   removes it from scheduling.
//
// Ports
//   clk, reset      single clock, synchronous active-high reset
//   cmd_valid/ready command handshake (ready is high outside reset)
//   cmd_id          0=set target, 1=identify, 2=set step, 3=hold
//   cmd_chan        channel for ids 0 and 3
//   cmd_data        command payload
//   dcm_prog_en     per-channel PROGEN (only the channel being programmed)
//   dcm_prog_data   shared PROGDATA
//   dcm_prog_done   per-channel PROGDONE
//   cur_mult        M last programmed per channel, ch0 in [7:0]
//   busy            engine active or any channel off its target
//   error           sticky per-channel PROGDONE timeout
//   identify        identify LED flag
// ---------------------------------------------------------------------------
module dcm_ramp_controller #(
    parameter int NUM_DCM            = 4,
    parameter int CHW                = 2,
    parameter int MAXIMUM_MULTIPLIER = 128,
    parameter int MINIMUM_MULTIPLIER = 20,
    parameter int INITIAL_MULTIPLIER = 60,
    parameter int DIVIDER            = 40,
    parameter int DEFAULT_STEP       = 4,
    parameter int SETTLE_CYCLES      = 1024,
    parameter int DONE_TIMEOUT       = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [7:0]             cmd_id,
    input  logic [CHW-1:0]         cmd_chan,
    input  logic [7:0]             cmd_data,
    output logic [NUM_DCM-1:0]     dcm_prog_en,
    output logic                   dcm_prog_data,
    input  logic [NUM_DCM-1:0]     dcm_prog_done,
    output logic [8*NUM_DCM-1:0]   cur_mult,
    output logic                   busy,
    output logic [NUM_DCM-1:0]     error,
    output logic                   identify
);

    localparam int TMAX = (SETTLE_CYCLES > DONE_TIMEOUT) ? SETTLE_CYCLES : DONE_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [7:0] M_INIT = 8'(INITIAL_MULTIPLIER);
    localparam logic [7:0] M_MIN  = 8'(MINIMUM_MULTIPLIER);
    localparam logic [7:0] M_MAX  = 8'(MAXIMUM_MULTIPLIER);
    localparam logic [7:0] D_M1   = 8'(DIVIDER - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT, S_SETTLE} state_t;

    state_t                    state_q, state_d;
    logic [NUM_DCM-1:0][7:0]   cur_q, cur_d;
    logic [NUM_DCM-1:0][7:0]   tgt_q, tgt_d;
    logic [NUM_DCM-1:0]        err_q, err_d;
    logic [7:0]                step_q, step_d;
    logic                      ident_q, ident_d;
    logic [CHW-1:0]            rr_q, rr_d;
    logic [CHW-1:0]            ch_q, ch_d;
    logic [7:0]                next_q, next_d;
    logic [15:0]               shreg_q, shreg_d;   // {M-1, D-1}
    logic [4:0]                ps_q, ps_d;
    logic [TW-1:0]             timer_q, timer_d;

    // ---------------- channel selection (round robin from rr_q) -------------
    logic [NUM_DCM-1:0] elig;
    logic               pick_found, hi_found, lo_found;
    logic [CHW-1:0]     pick_ch, hi_ch, lo_ch;
    logic [7:0]         pick_cur, pick_tgt, hi_cur, hi_tgt, lo_cur, lo_tgt;

    always_comb begin
        hi_found = 1'b0; hi_ch = '0; hi_cur = '0; hi_tgt = '0;
        lo_found = 1'b0; lo_ch = '0; lo_cur = '0; lo_tgt = '0;
        for (int i = 0; i < NUM_DCM; i++)
            elig[i] = (tgt_q[i] != cur_q[i]) && !err_q[i];
        // Descending scan: the last hit is the lowest index. "hi" is the
        // lowest eligible at/after rr, "lo" the lowest overall (wrap case).
        for (int i = NUM_DCM - 1; i >= 0; i--) begin
            if (elig[i]) begin
                lo_found = 1'b1; lo_ch = CHW'(i); lo_cur = cur_q[i]; lo_tgt = tgt_q[i];
                if (CHW'(i) >= rr_q) begin
                    hi_found = 1'b1; hi_ch = CHW'(i); hi_cur = cur_q[i]; hi_tgt = tgt_q[i];
                end
            end
        end
        pick_found = lo_found;
        pick_ch    = hi_found ? hi_ch  : lo_ch;
        pick_cur   = hi_found ? hi_cur : lo_cur;
        pick_tgt   = hi_found ? hi_tgt : lo_tgt;
    end

    // Next M with 9-bit headroom so cur+step / tgt+step never wrap.
    logic [8:0] up_sum, dn_lim;
    logic [7:0] pick_next;

    always_comb begin
        up_sum = {1'b0, pick_cur} + {1'b0, step_q};
        dn_lim = {1'b0, pick_tgt} + {1'b0, step_q};
        if (pick_tgt > pick_cur)
            pick_next = (up_sum > {1'b0, pick_tgt}) ? pick_tgt : up_sum[7:0];
        else
            pick_next = ({1'b0, pick_cur} < dn_lim) ? pick_tgt : (pick_cur - step_q);
    end

    // ---------------- active channel helpers ---------------------------------
    logic [NUM_DCM-1:0] sel_oh;
    logic               sel_done, timed_out, settled;

    always_comb begin
        for (int i = 0; i < NUM_DCM; i++)
            sel_oh[i] = (ch_q == CHW'(i));
        sel_done  = |(dcm_prog_done & sel_oh);
        timed_out = (timer_q == TW'(DONE_TIMEOUT - 1));
        settled   = (timer_q == TW'(SETTLE_CYCLES - 1));
    end

    // ---------------- FSM: state register ------------------------------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state -----------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (pick_found)             state_d = S_SHIFT;
            S_SHIFT:  if (ps_q == 5'd26)          state_d = S_WAIT;
            S_WAIT:   if (sel_done || timed_out)  state_d = S_SETTLE;
            S_SETTLE: if (settled)                state_d = S_IDLE;
            default:                              state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (serial programming frame) -----------------
    logic en_bit, data_bit;

    always_comb begin
        en_bit   = 1'b0;
        data_bit = 1'b0;
        if (state_q == S_SHIFT) begin
            case (ps_q) inside
                5'd0:           begin en_bit = 1'b1; data_bit = 1'b1; end
                5'd1:           en_bit = 1'b1;
                [5'd2:5'd9]:    begin en_bit = 1'b1; data_bit = shreg_q[4'(ps_q - 5'd2)]; end
                5'd13, 5'd14:   begin en_bit = 1'b1; data_bit = 1'b1; end
                [5'd15:5'd22]:  begin en_bit = 1'b1; data_bit = shreg_q[4'(ps_q - 5'd7)]; end
                5'd25:          en_bit = 1'b1;   // GO
                default:        ;
            endcase
        end
        dcm_prog_en   = en_bit ? sel_oh : '0;
        dcm_prog_data = data_bit;
    end

    // ---------------- datapath next state -------------------------------------
    logic       cmd_acc;
    logic [7:0] clamped;

    always_comb begin
        cmd_acc = cmd_valid && cmd_ready;
        if (cmd_data < M_MIN)      clamped = M_MIN;
        else if (cmd_data > M_MAX) clamped = M_MAX;
        else                       clamped = cmd_data;
    end

    always_comb begin
        cur_d   = cur_q;   tgt_d   = tgt_q;   err_d  = err_q;
        step_d  = step_q;  ident_d = ident_q; rr_d   = rr_q;
        ch_d    = ch_q;    next_d  = next_q;  shreg_d = shreg_q;
        ps_d    = ps_q;    timer_d = timer_q;

        case (state_q)
            S_IDLE: if (pick_found) begin
                ch_d    = pick_ch;
                next_d  = pick_next;
                shreg_d = {pick_next - 8'd1, D_M1};
                ps_d    = '0;
                rr_d    = (pick_ch == CHW'(NUM_DCM - 1)) ? '0 : pick_ch + 1'b1;
            end
            S_SHIFT: begin
                ps_d    = ps_q + 5'd1;
                timer_d = '0;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                for (int i = 0; i < NUM_DCM; i++) begin
                    if (sel_oh[i]) begin
                        if (dcm_prog_done[i]) cur_d[i] = next_q;   // done wins a tie
                        else if (timed_out)   err_d[i] = 1'b1;
                    end
                end
                if (sel_done || timed_out) timer_d = '0;
            end
            S_SETTLE: timer_d = timer_q + 1'b1;
            default: ;
        endcase

        // Commands apply after the engine so an id0 clear beats a same-cycle
        // timeout. A channel number >= NUM_DCM matches no loop index and is
        // therefore ignored.
        if (cmd_acc) begin
            case (cmd_id)
                8'd0: for (int i = 0; i < NUM_DCM; i++)
                          if (cmd_chan == CHW'(i)) begin
                              tgt_d[i] = clamped;
                              err_d[i] = 1'b0;
                          end
                8'd1: ident_d = cmd_data[0];
                8'd2: step_d  = (cmd_data == 8'd0) ? 8'd1 : cmd_data;
                8'd3: for (int i = 0; i < NUM_DCM; i++)
                          if (cmd_chan == CHW'(i)) tgt_d[i] = cur_q[i];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q   <= {NUM_DCM{M_INIT}};
            tgt_q   <= {NUM_DCM{M_INIT}};
            err_q   <= '0;
            step_q  <= 8'(DEFAULT_STEP);
            ident_q <= 1'b0;
            rr_q    <= '0;
            ch_q    <= '0;
            next_q  <= M_INIT;
            shreg_q <= '0;
            ps_q    <= '0;
            timer_q <= '0;
        end else begin
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            err_q   <= err_d;
            step_q  <= step_d;
            ident_q <= ident_d;
            rr_q    <= rr_d;
            ch_q    <= ch_d;
            next_q  <= next_d;
            shreg_q <= shreg_d;
            ps_q    <= ps_d;
            timer_q <= timer_d;
        end
    end

    // ---------------- status outputs ------------------------------------------
    logic off_target;

    always_comb begin
        off_target = 1'b0;
        for (int i = 0; i < NUM_DCM; i++)
            if (tgt_q[i] != cur_q[i]) off_target = 1'b1;
    end

    assign cmd_ready = !reset;
    assign cur_mult  = cur_q;
    assign busy      = (state_q != S_IDLE) || off_target;
    assign error     = err_q;
    assign identify  = ident_q;

endmodule

// File: tb/tb_dcm_ramp_controller.sv
module tb_dcm_ramp_controller;

    localparam int N  = 4;
    localparam int CW = 3;     // wide enough to present cmd_chan == N
    localparam int ST = 16;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [7:0]     cmd_id = '0;
    logic [CW-1:0]  cmd_chan = '0;
    logic [7:0]     cmd_data = '0;
    logic [N-1:0]   dcm_prog_en;
    logic           dcm_prog_data;
    logic [N-1:0]   dcm_prog_done = '0;
    logic [8*N-1:0] cur_mult;
    logic           busy;
    logic [N-1:0]   error;
    logic           identify;

    dcm_ramp_controller #(
        .NUM_DCM(N), .CHW(CW), .MAXIMUM_MULTIPLIER(128), .MINIMUM_MULTIPLIER(20),
        .INITIAL_MULTIPLIER(60), .DIVIDER(40), .DEFAULT_STEP(4),
        .SETTLE_CYCLES(ST), .DONE_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
        .cmd_chan(cmd_chan), .cmd_data(cmd_data),
        .dcm_prog_en(dcm_prog_en), .dcm_prog_data(dcm_prog_data),
        .dcm_prog_done(dcm_prog_done), .cur_mult(cur_mult), .busy(busy),
        .error(error), .identify(identify)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int prog_ch[$];
    int prog_m[$];
    logic [N-1:0] blk = '0;

    // Expected frame shape by position: en pattern, and data at the
    // fixed (non-payload) positions.
    logic [26:0] en_pat   = {1'b0, 1'b1, 2'b00, 10'h3FF, 3'b000, 10'h3FF};
    logic [26:0] dfix_val = 27'h0006001;
    logic [26:0] dfix_msk = 27'h7807C03;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // DCM model: decodes each frame, checks its shape, logs (channel, M) and
    // answers PROGDONE three cycles after the frame unless blocked.
    bit       in_prog = 1'b0;
    int       k = 0, mch = 0, dcnt = 0, dch = 0;
    logic [7:0] dw = '0, mw = '0;

    always @(negedge clk) begin
        if (reset) begin
            in_prog = 1'b0;
            dcnt = 0;
            dcm_prog_done = '0;
        end else begin
            dcm_prog_done = '0;
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0 && ((blk >> dch) & 4'b0001) == 4'b0000)
                    dcm_prog_done = 4'(1 << dch);
            end
            if (!in_prog && dcm_prog_en != '0) begin
                in_prog = 1'b1;
                k = 0;
                chk("en_onehot", 32'($countones(dcm_prog_en)), 32'd1);
                for (int i = N - 1; i >= 0; i--)
                    if (((dcm_prog_en >> i) & 4'b0001) != 4'b0000) mch = i;
            end
            if (in_prog) begin
                chk("frame_en", 32'(dcm_prog_en),
                    (((en_pat >> k) & 27'd1) != 27'd0) ? 32'(1 << mch) : 32'd0);
                if (((dfix_msk >> k) & 27'd1) != 27'd0)
                    chk("frame_data", 32'(dcm_prog_data), 32'((dfix_val >> k) & 27'd1));
                if (k >= 2 && k <= 9)   dw = {dcm_prog_data, dw[7:1]};
                if (k >= 15 && k <= 22) mw = {dcm_prog_data, mw[7:1]};
                if (k == 26) begin
                    in_prog = 1'b0;
                    chk("divider_m1", 32'(dw), 32'd39);
                    prog_ch.push_back(mch);
                    prog_m.push_back(int'(mw) + 1);
                    dcnt = 3;
                    dch  = mch;
                end
                k++;
            end
        end
    end

    task automatic send(input logic [7:0] id, input int ch, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_id    = id;
        cmd_chan  = CW'(ch);
        cmd_data  = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic clear_q();
        prog_ch.delete();
        prog_m.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic chk_prog(input string tag, input int idx, input int ch, input int m);
        if (idx < prog_m.size()) begin
            chk({tag, "_ch"}, 32'(prog_ch[idx]), 32'(ch));
            chk({tag, "_m"},  32'(prog_m[idx]),  32'(m));
        end else
            chk({tag, "_missing"}, 32'(prog_m.size()), 32'(idx + 1));
    endtask

    initial begin
        int n;
        // ---- reset state
        repeat (3) @(negedge clk);
        chk("ready_in_reset", 32'(cmd_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cur",   cur_mult, 32'h3C3C3C3C);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_err",   32'(error), 32'd0);
        chk("rst_ident", 32'(identify), 32'd0);
        chk("rst_en",    32'(dcm_prog_en), 32'd0);
        chk("rst_data",  32'(dcm_prog_data), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);

        // ---- ch0 60 -> 72 in steps of 4
        clear_q();
        send(8'd0, 0, 8'd72);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_idle(2000);
        chk("t1_count", 32'(prog_m.size()), 32'd3);
        chk_prog("t1_p0", 0, 0, 64);
        chk_prog("t1_p1", 1, 0, 68);
        chk_prog("t1_p2", 2, 0, 72);
        chk("t1_cur0", 32'(cur_mult[7:0]), 32'd72);

        // ---- clamp high: 200 -> 128
        clear_q();
        send(8'd0, 1, 8'd200);
        wait_idle(3000);
        chk("t2_up_count", 32'(prog_m.size()), 32'd17);
        chk_prog("t2_up_first", 0, 1, 64);
        chk_prog("t2_up_last", 16, 1, 128);
        chk("t2_cur1_hi", 32'(cur_mult[15:8]), 32'd128);

        // ---- clamp low: 5 -> 20, step 16, partial last step
        clear_q();
        send(8'd2, 0, 8'd16);
        send(8'd0, 1, 8'd5);
        wait_idle(1000);
        chk("t2_dn_count", 32'(prog_m.size()), 32'd7);
        chk_prog("t2_dn_p5", 5, 1, 32);
        chk_prog("t2_dn_p6", 6, 1, 20);
        chk("t2_cur1_lo", 32'(cur_mult[15:8]), 32'd20);

        clear_q();
        send(8'd0, 2, 8'd5);
        wait_idle(1000);
        chk("t2_ch2_count", 32'(prog_m.size()), 32'd3);
        chk_prog("t2_ch2_p0", 0, 2, 44);
        chk_prog("t2_ch2_p1", 1, 2, 28);
        chk_prog("t2_ch2_p2", 2, 2, 20);

        // ---- round robin between ch0 and ch2
        clear_q();
        send(8'd2, 0, 8'd4);
        send(8'd0, 0, 8'd80);
        send(8'd0, 2, 8'd28);
        wait_idle(1000);
        chk("t3_count", 32'(prog_m.size()), 32'd4);
        chk_prog("t3_p0", 0, 0, 76);
        chk_prog("t3_p1", 1, 2, 24);
        chk_prog("t3_p2", 2, 0, 80);
        chk_prog("t3_p3", 3, 2, 28);
        chk("t3_cur", cur_mult, 32'h3C1C1450);

        // ---- PROGDONE timeout on ch3
        clear_q();
        blk = 4'b1000;
        send(8'd0, 3, 8'd64);
        n = 0;
        while (prog_m.size() < 1 && n < 200) begin @(negedge clk); n++; end
        chk("t4_frame_seen", 32'(prog_m.size()), 32'd1);
        repeat (50) @(negedge clk);
        chk("t4_err_early", 32'(error), 32'd0);
        n = 0;
        while (error == '0 && n < 40) begin @(negedge clk); n++; end
        chk("t4_err_set", 32'(error), 32'h8);
        chk("t4_cur3_kept", 32'(cur_mult[31:24]), 32'd60);
        repeat (100) @(negedge clk);
        chk("t4_skipped", 32'(prog_m.size()), 32'd1);
        chk("t4_busy", 32'(busy), 32'd1);
        chk_prog("t4_p0", 0, 3, 64);
        blk = '0;
        send(8'd0, 3, 8'd64);
        chk("t4_err_clr", 32'(error), 32'd0);
        wait_idle(1000);
        chk("t4_resume_count", 32'(prog_m.size()), 32'd2);
        chk_prog("t4_p1", 1, 3, 64);
        chk("t4_cur3", 32'(cur_mult[31:24]), 32'd64);

        // ---- misc commands, ignored commands, hold mid-ramp
        clear_q();
        send(8'd2, 0, 8'd0);
        send(8'd1, 0, 8'd1);
        chk("t5_ident_on", 32'(identify), 32'd1);
        send(8'd1, 0, 8'd2);
        chk("t5_ident_bit0", 32'(identify), 32'd0);
        send(8'd1, 0, 8'd1);
        send(8'd5, 0, 8'd0);
        send(8'd7, 0, 8'd99);
        send(8'd4, 0, 8'd99);
        send(8'd0, N, 8'd100);
        repeat (5) @(negedge clk);
        chk("t5_ident_kept", 32'(identify), 32'd1);
        chk("t5_ignored_busy", 32'(busy), 32'd0);
        chk("t5_ignored_cur", cur_mult, 32'h401C1450);
        chk("t5_ignored_prog", 32'(prog_m.size()), 32'd0);
        send(8'd0, 0, 8'd90);
        n = 0;
        while (cur_mult[7:0] != 8'd81 && n < 200) begin @(negedge clk); n++; end
        chk("t5_first_step", 32'(cur_mult[7:0]), 32'd81);
        send(8'd3, 0, 8'd0);
        wait_idle(500);
        chk("t5_hold_count", 32'(prog_m.size()), 32'd1);
        chk_prog("t5_p0", 0, 0, 81);
        chk("t5_cur0", 32'(cur_mult[7:0]), 32'd81);

        // ---- reset in the middle of a frame (ps=18)
        clear_q();
        send(8'd0, 1, 8'd25);
        n = 0;
        while (dcm_prog_en == '0 && n < 50) begin @(negedge clk); n++; end
        repeat (18) @(negedge clk);
        chk("t6_ps18_en", 32'(dcm_prog_en), 32'h2);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_en",    32'(dcm_prog_en), 32'd0);
        chk("t6_data",  32'(dcm_prog_data), 32'd0);
        chk("t6_cur",   cur_mult, 32'h3C3C3C3C);
        chk("t6_busy",  32'(busy), 32'd0);
        chk("t6_ident", 32'(identify), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        chk("t6_no_prog", 32'(prog_m.size()), 32'd0);
        chk("t6_idle",    32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
